// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    // Fetch stage side: issues the request, receives the instruction word.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    // Memory side: observes the request, returns ready/rdata.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch_pc sequencing, IF/ID register and a
// one-entry skid buffer that absorbs a fetch completing under a decode stall.
module if_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [31:0]       branch_addr,
    if_stage_if.master        imem,
    output logic [31:0]       instruction,
    output logic [31:0]       PC,
    output logic              valid
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    typedef enum logic {FETCH, FULL} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] fetch_pc, fetch_pc_n;
    logic [XLEN-1:0] sk_instr, sk_instr_n;
    logic [XLEN-1:0] sk_pc, sk_pc_n;
    logic [XLEN-1:0] instr_n, pc_n;
    logic            valid_n;
    logic            done;

    // A request is only outstanding in FETCH and never while reset is held.
    assign imem.imem_req  = rst && (state == FETCH);
    assign imem.imem_addr = fetch_pc;

    // Next-state and IF/ID/skid next values; branch redirect has top priority.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        sk_instr_n = sk_instr;
        sk_pc_n    = sk_pc;
        instr_n    = instruction;
        pc_n       = PC;
        valid_n    = valid;
        done       = (state == FETCH) && imem.imem_ready;

        if (branch_taken) begin
            fetch_pc_n = branch_addr & ~XLEN'(3);
            instr_n    = '0;
            valid_n    = 1'b0;
            sk_instr_n = '0;
            sk_pc_n    = '0;
            state_n    = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (done) begin
                        fetch_pc_n = fetch_pc + STEP;
                        if (freeze) begin
                            sk_instr_n = imem.imem_rdata;
                            sk_pc_n    = fetch_pc + STEP;
                            state_n    = FULL;
                        end else begin
                            instr_n = imem.imem_rdata;
                            pc_n    = fetch_pc + STEP;
                            valid_n = 1'b1;
                        end
                    end else if (!freeze) begin
                        instr_n = '0;
                        valid_n = 1'b0;
                    end
                end
                FULL: begin
                    if (!freeze) begin
                        instr_n = sk_instr;
                        pc_n    = sk_pc;
                        valid_n = 1'b1;
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // State, fetch address, skid buffer and IF/ID register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            fetch_pc    <= '0;
            sk_instr    <= '0;
            sk_pc       <= '0;
            instruction <= '0;
            PC          <= '0;
            valid       <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            sk_instr    <= sk_instr_n;
            sk_pc       <= sk_pc_n;
            instruction <= instr_n;
            PC          <= pc_n;
            valid       <= valid_n;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage against a queue-based fetch model.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] instruction, PC;
    logic        valid;

    if_stage_if imem ();

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem),
        .instruction  (instruction),
        .PC           (PC),
        .valid        (valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: next fetch address, fetched-but-undelivered words, IF/ID view.
    logic [31:0] m_fetch;
    logic [63:0] held[$];
    logic [31:0] m_instr, m_pc;
    logic        m_valid;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_1005;
        if (a == 32'h4) return 32'hE281_1001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory returns the word at whatever address is presented.
    always_comb imem.imem_rdata = word(imem.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch = '0;
        held.delete();
        m_instr = '0;
        m_pc    = '0;
        m_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check({tag, ".instr"}, instruction, m_instr);
        check({tag, ".pc"}, PC, m_pc);
    endtask

    // One clock: drive inputs, check request side, clock, advance model, check IF/ID.
    task automatic step(input logic f, input logic b, input logic [31:0] ba, input logic r);
        logic [63:0] e;
        @(negedge clk);
        freeze          = f;
        branch_taken    = b;
        branch_addr     = ba;
        imem.imem_ready = r;
        #1;
        check("req", 32'(imem.imem_req), 32'(held.size() == 0));
        check("addr", imem.imem_addr, m_fetch);
        if (b) begin
            m_instr = '0;
            m_valid = 1'b0;
            held.delete();
            m_fetch = ba & 32'hFFFF_FFFC;
        end else if (held.size() != 0) begin
            if (!f) begin
                e = held.pop_front();
                m_instr = e[63:32];
                m_pc    = e[31:0];
                m_valid = 1'b1;
            end
        end else if (r) begin
            e = {word(m_fetch), m_fetch + 32'd4};
            m_fetch = m_fetch + 32'd4;
            if (f) held.push_back(e);
            else begin
                m_instr = e[63:32];
                m_pc    = e[31:0];
                m_valid = 1'b1;
            end
        end else if (!f) begin
            m_instr = '0;
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs("step");
    endtask

    // Asynchronous reset away from any edge, with a stray ready during reset.
    task automatic do_reset();
        @(negedge clk);
        #2;
        imem.imem_ready = 1'b1;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst.req", 32'(imem.imem_req), 32'h0);
        check("rst.addr", imem.imem_addr, 32'h0);
        check_outputs("rst");
        @(posedge clk);
        #1;
        check_outputs("rst_edge");
        #1;
        rst = 1'b1;
    endtask

    initial begin
        imem.imem_ready = 1'b0;
        model_reset();
        #3;
        check("por.req", 32'(imem.imem_req), 32'h0);
        check_outputs("por");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Back-to-back fetches from address 0.
        step(0, 0, 0, 1);
        check("first.instr", instruction, 32'hE3A0_1005);
        check("first.pc", PC, 32'h4);
        step(0, 0, 0, 1);
        check("second.instr", instruction, 32'hE281_1001);
        check("second.pc", PC, 32'h8);

        // Three wait cycles at 0x10.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (3) begin
            step(0, 0, 0, 0);
            check("wait.addr", imem.imem_addr, 32'h10);
            check("wait.valid", 32'(valid), 32'h0);
        end
        step(0, 0, 0, 1);
        check("wait.pc", PC, 32'h14);

        // Freeze for four cycles while completing 0x20.
        repeat (3) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        repeat (3) step(1, 0, 0, $urandom_range(0, 1));
        check("frz.req", 32'(imem.imem_req), 32'h0);
        step(0, 0, 0, 0);
        check("frz.instr", instruction, word(32'h20));
        check("frz.pc", PC, 32'h24);
        check("frz.next", imem.imem_addr, 32'h24);

        // Branch overrides freeze and a coincident completion.
        step(1, 1, 32'h100, 1);
        check("br.valid", 32'(valid), 32'h0);
        check("br.addr", imem.imem_addr, 32'h100);

        // Branch while the skid holds a word.
        step(1, 0, 0, 1);
        step(1, 1, 32'h200, 0);
        step(0, 0, 0, 1);
        check("brfull.pc", PC, 32'h204);

        // Wrap at the top of memory; low branch bits ignored.
        step(0, 1, 32'hFFFF_FFFF, 1);
        step(0, 0, 0, 1);
        check("wrap.pc", PC, 32'h0);
        check("wrap.addr", imem.imem_addr, 32'h0);

        // Reset in the middle of a pending handshake.
        step(0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 1);
        check("postrst.pc", PC, 32'h4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0,
                 $urandom,
                 $urandom_range(0, 9) < 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
